// File: rtl/leiwand_rv32_gpio.sv
// Memory-mapped GPIO for leiwand_rv32: per-pin direction, synchronised input and edge IRQs.
// Optional input debounce is built when GPIO_DEBOUNCE_EN is defined.

module leiwand_rv32_gpio_pin #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic pad,
  input  logic armed,
  input  logic irq_type,
  output logic f,
  output logic evt
);
  logic [1:0] sync;
  logic       prev;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[0], pad};
      prev <= f;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] cnt;

  // f only follows the synchronised value after it has disagreed for a full window
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
      f   <= 1'b0;
    end else if (sync[1] == f) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt <= '0;
      f   <= sync[1];
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  localparam int unused_db = DEBOUNCE_CYCLES;
  assign f = sync[1];
`endif

  assign evt = armed & (irq_type ? (~f & prev) : (f & ~prev));
endmodule

module leiwand_rv32_gpio #(
  parameter int          NUM_PINS        = 8,
  parameter logic [31:0] BASE_ADDR       = 32'h3000_0000,
  parameter int          DEBOUNCE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                mem_valid,
  output logic                mem_ready,
  input  logic [31:0]         mem_addr,
  input  logic [31:0]         mem_wdata,
  input  logic [3:0]          mem_wen,
  output logic [31:0]         mem_rdata,
  input  logic [NUM_PINS-1:0] gpio_in,
  output logic [NUM_PINS-1:0] gpio_out,
  output logic [NUM_PINS-1:0] gpio_oe,
  output logic                irq
);
  typedef struct packed {
    logic [2:0]  off;
    logic [31:0] mask;
    logic [31:0] data;
  } req_t;

  req_t                req;
  logic                sel, acc, armed;
  logic [1:0]          arm_cnt;
  logic [NUM_PINS-1:0] wm, wd, clr;
  logic [NUM_PINS-1:0] out_r, dir_r, en_r, pend_r, type_r, in_f, evt;
  logic [31:0]         rd_val, rdata_q;

  assign req.off  = mem_addr[4:2];
  assign req.mask = {{8{mem_wen[3]}}, {8{mem_wen[2]}}, {8{mem_wen[1]}}, {8{mem_wen[0]}}};
  assign req.data = mem_wdata;

  assign sel   = mem_valid && (mem_addr[31:5] == BASE_ADDR[31:5]);
  assign acc   = sel && !mem_ready;
  assign wm    = req.mask[NUM_PINS-1:0];
  assign wd    = req.data[NUM_PINS-1:0];
  assign armed = &arm_cnt;
  assign clr   = (acc && req.off == 3'd4) ? (wd & wm) : '0;

  logic unused_bits;
  assign unused_bits = ^{mem_addr[1:0], req.mask, req.data};

  for (genvar p = 0; p < NUM_PINS; p++) begin : g_pin
    leiwand_rv32_gpio_pin #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pin (
      .clk      (clk),
      .resetn   (resetn),
      .pad      (gpio_in[p]),
      .armed    (armed),
      .irq_type (type_r[p]),
      .f        (in_f[p]),
      .evt      (evt[p])
    );
  end

  always_comb begin
    rd_val = '0;
    case (req.off)
      3'd0:    rd_val[NUM_PINS-1:0] = out_r;
      3'd1:    rd_val[NUM_PINS-1:0] = dir_r;
      3'd2:    rd_val[NUM_PINS-1:0] = in_f;
      3'd3:    rd_val[NUM_PINS-1:0] = en_r;
      3'd4:    rd_val[NUM_PINS-1:0] = pend_r;
      3'd5:    rd_val[NUM_PINS-1:0] = type_r;
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_ready <= 1'b0;
      rdata_q   <= '0;
      out_r     <= '0;
      dir_r     <= '0;
      en_r      <= '0;
      pend_r    <= '0;
      type_r    <= '0;
      arm_cnt   <= '0;
    end else begin
      mem_ready <= acc;
      if (!armed) arm_cnt <= arm_cnt + 1'b1;
      // a hardware set in the same cycle as a W1C leaves the bit set
      pend_r <= (pend_r & ~clr) | evt;
      if (acc) begin
        rdata_q <= rd_val;
        case (req.off)
          3'd0: out_r  <= (out_r  & ~wm) | (wd & wm);
          3'd1: dir_r  <= (dir_r  & ~wm) | (wd & wm);
          3'd3: en_r   <= (en_r   & ~wm) | (wd & wm);
          3'd5: type_r <= (type_r & ~wm) | (wd & wm);
          default: ;
        endcase
      end
    end
  end

  assign mem_rdata = mem_ready ? rdata_q : '0;
  assign gpio_out  = out_r;
  assign gpio_oe   = dir_r;
  assign irq       = |(pend_r & en_r);
endmodule

// File: tb/tb_leiwand_rv32_gpio.sv
// Scoreboard bench for leiwand_rv32_gpio: bus reads push expectations, acks pop and compare.
module tb_leiwand_rv32_gpio;
  localparam int          NP   = 8;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic          clk = 1'b0;
  logic          resetn;
  logic          mem_valid, mem_ready;
  logic [31:0]   mem_addr, mem_wdata, mem_rdata;
  logic [3:0]    mem_wen;
  logic [NP-1:0] gpio_in, gpio_out, gpio_oe;
  logic          irq;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  leiwand_rv32_gpio #(.NUM_PINS(NP), .BASE_ADDR(BASE), .DEBOUNCE_CYCLES(16)) dut (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_rdata(mem_rdata),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // one access starting at a negedge; also checks ready drops right after the ack
  task automatic bus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wen,
                     output logic [31:0] rdata);
    bit got = 0;
    rdata = 'x;
    mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata; mem_wen = wen;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if (mem_ready) begin got = 1; rdata = mem_rdata; end
    end
    mem_valid = 1'b0; mem_wen = 4'h0;
    checks++;
    if (!got) begin errors++; $display("FAIL ack_timeout addr=%h got no ready, expected ready", addr); end
    @(negedge clk);
    checks++;
    if (mem_ready !== 1'b0 || mem_rdata !== 32'h0) begin
      errors++; $display("FAIL ready_one_cycle got ready=%b rdata=%h, expected 0/0", mem_ready, mem_rdata);
    end
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] d, input logic [3:0] wen = 4'hF);
    logic [31:0] r;
    bus(BASE + {27'd0, off, 2'b00}, d, wen, r);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
    logic [31:0] r, e;
    exp_q.push_back(exp);
    bus(addr, 32'hDEAD_BEEF, 4'h0, r);
    e = exp_q.pop_front();
    checks++;
    if (r !== e) begin errors++; $display("FAIL %s got %h expected %h", name, r, e); end
  endtask

  task automatic chk1(input logic a, input logic e, input string name);
    checks++;
    if (a !== e) begin errors++; $display("FAIL %s got %b expected %b", name, a, e); end
  endtask

  task automatic test_reset;
    resetn = 1'b0; mem_valid = 0; mem_addr = 0; mem_wdata = 0; mem_wen = 0;
    gpio_in = 8'h04;
    cyc(3);
    checks++;
    if ({mem_ready, mem_rdata, gpio_out, gpio_oe, irq} !== '0) begin
      errors++;
      $display("FAIL reset_state got ready=%b rdata=%h out=%h oe=%h irq=%b, expected all 0",
               mem_ready, mem_rdata, gpio_out, gpio_oe, irq);
    end
    resetn = 1'b1;
    cyc(8);
    rd(BASE + 32'h08, 32'h04, "in_after_reset");
`ifndef GPIO_DEBOUNCE_EN
    rd(BASE + 32'h10, 32'h00, "pend_pin_high_at_reset");
`endif
  endtask

  task automatic test_rw;
    wr(0, 32'h0000_00A5);
    wr(1, 32'h0000_000F);
    checks++;
    if (gpio_out !== 8'hA5 || gpio_oe !== 8'h0F) begin
      errors++; $display("FAIL pad_out got out=%h oe=%h expected a5/0f", gpio_out, gpio_oe);
    end
    rd(BASE + 32'h00, 32'h0000_00A5, "out_readback");
    rd(BASE + 32'h04, 32'h0000_000F, "dir_readback");
    rd(BASE + 32'h01, 32'h0000_00A5, "out_unaligned_addr");
  endtask

  task automatic test_byte_lane;
    wr(0, 32'h0);
    wr(0, 32'h1234_5678, 4'b0001);
    rd(BASE + 32'h00, 32'h78, "out_lane0");
    wr(0, 32'h1234_5600, 4'b0100);
    rd(BASE + 32'h00, 32'h78, "out_lane2_ignored");
    wr(6, 32'hFFFF_FFFF);
    rd(BASE + 32'h18, 32'h0, "offset6_read");
  endtask

  task automatic test_select;
    int seen = 0;
    mem_valid = 1'b1; mem_addr = BASE + 32'h20; mem_wen = 4'hF; mem_wdata = 32'hFF;
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (mem_ready) seen++; end
    mem_valid = 1'b0; mem_wen = 4'h0;
    checks++;
    if (seen != 0) begin errors++; $display("FAIL out_of_window_ack got %0d acks expected 0", seen); end
    rd(BASE + 32'h00, 32'h78, "out_untouched_by_other_window");
  endtask

  task automatic test_back_to_back;
    logic [3:0] pat = '0;
    logic [3:0] exp_pat = 4'b0101;
    mem_valid = 1'b1; mem_addr = BASE + 32'h04; mem_wen = 4'h0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); pat[i] = mem_ready; end
    mem_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (pat !== exp_pat) begin errors++; $display("FAIL held_valid_ready got %b expected %b", pat, exp_pat); end
  endtask

  task automatic test_irq_rise;
    wr(3, 32'h08);
    gpio_in[3] = 1'b1;
    cyc(2);
    chk1(irq, 1'b0, "irq_before_3_edges");
    cyc(1);
    chk1(irq, 1'b1, "irq_at_3_edges");
    rd(BASE + 32'h10, 32'h08, "pend_rise3");
    wr(4, 32'h08);
    chk1(irq, 1'b0, "irq_after_w1c");
    rd(BASE + 32'h10, 32'h00, "pend_cleared");
    gpio_in[4] = 1'b1;
    cyc(5);
    chk1(irq, 1'b0, "irq_masked_pending");
    rd(BASE + 32'h10, 32'h10, "pend_latched_disabled");
    wr(3, 32'h18);
    chk1(irq, 1'b1, "irq_on_enable");
    wr(4, 32'h10);
    chk1(irq, 1'b0, "irq_after_clear4");
  endtask

  task automatic test_fall;
    wr(5, 32'h02);
    gpio_in[1] = 1'b1;
    cyc(5);
    rd(BASE + 32'h10, 32'h00, "pend_no_rise_when_falling");
    gpio_in[1] = 1'b0;
    cyc(5);
    rd(BASE + 32'h10, 32'h02, "pend_on_fall");
    wr(5, 32'h00);
    rd(BASE + 32'h10, 32'h02, "pend_kept_after_type_change");
    wr(4, 32'h02);
    rd(BASE + 32'h10, 32'h00, "pend_fall_cleared");
  endtask

  task automatic test_collision;
    gpio_in[3] = 1'b0;
    cyc(5);
    rd(BASE + 32'h10, 32'h00, "pend_before_collision");
    gpio_in[3] = 1'b1;
    cyc(2);
    mem_valid = 1'b1; mem_addr = BASE + 32'h10; mem_wdata = 32'h08; mem_wen = 4'hF;
    @(negedge clk);
    chk1(mem_ready, 1'b1, "collision_ack");
    mem_valid = 1'b0; mem_wen = 4'h0;
    @(negedge clk);
    rd(BASE + 32'h10, 32'h08, "set_wins_over_w1c");
    wr(4, 32'h08);
  endtask

`ifdef GPIO_DEBOUNCE_EN
  task automatic test_debounce;
    wr(3, 32'h01);
    wr(4, 32'hFF);
    gpio_in[0] = 1'b1;
    cyc(10);
    gpio_in[0] = 1'b0;
    cyc(25);
    rd(BASE + 32'h08, {24'd0, gpio_in & 8'hFE}, "debounce_glitch_in");
    rd(BASE + 32'h10, 32'h00, "debounce_glitch_pend");
    gpio_in[0] = 1'b1;
    cyc(17);
    rd(BASE + 32'h08, {24'd0, gpio_in & 8'hFE}, "debounce_not_yet");
    cyc(5);
    rd(BASE + 32'h08, {24'd0, gpio_in}, "debounce_accepted");
    rd(BASE + 32'h10, 32'h01, "debounce_pend");
  endtask
`endif

  initial begin
    test_reset;
    test_rw;
    test_byte_lane;
    test_select;
    test_back_to_back;
    test_irq_rise;
    test_fall;
    test_collision;
`ifdef GPIO_DEBOUNCE_EN
    test_debounce;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
